// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod-MOD counter and its sequence monitor.
//   seq_state_t : monitor FSM encoding (IDLE/ACQ/LOCKED/FAULT)
//   DEF_WIDTH   : default counter bus width
//   DEF_MOD     : default counter modulus
package mod_counter_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_MOD   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/mod_counter_seq_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one event
//   clr        : clear; clr together with inc loads 1 (the event is kept)
//   count      : current value, holds at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= inc ? WIDTH'(1) : '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/mod_counter_seq_monitor.sv
// mod_counter_seq_monitor: checks a sampled mod-MOD counter bus steps
// 0,1,..,MOD-1,0, declares lock after LOCK_CNT good steps, flags errors and
// counts wraps seen while locked.
//   clk, reset : clock, synchronous active-high reset
//   en         : sample qualifier (0 = hold state, pulses drop)
//   q_in       : counter value under test
//   clr_err    : clears err_sticky (and err_count)
//   locked     : FSM is in LOCKED
//   seq_err    : one-cycle pulse per detected error
//   err_sticky : latched error flag
//   wrap_pulse : one-cycle pulse per MOD-1 -> 0 step while locked
//   wrap_count : saturating wrap count
//   err_count  : saturating error count (only with SEQMON_ERRCNT_EN defined)
module mod_counter_seq_monitor
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MOD      = DEF_MOD,
  parameter int LOCK_CNT = 2,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              seq_err,
  output logic              err_sticky,
  output logic              wrap_pulse,
`ifdef SEQMON_ERRCNT_EN
  output logic [7:0]        err_count,
`endif
  output logic [WRAP_W-1:0] wrap_count
);
  localparam int               GW    = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH compares correctly (nothing illegal).
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt, succ;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic             err_nxt, wrap_nxt, sticky_nxt;
  logic             illegal, match;

  assign succ    = (prev == TOP) ? '0 : prev + 1'b1;
  assign illegal = {1'b0, q_in} >= MOD_X;
  assign match   = (q_in == succ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      good_cnt   <= '0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      good_cnt   <= good_nxt;
      locked     <= (state_nxt == LOCKED);
      seq_err    <= err_nxt;
      wrap_pulse <= wrap_nxt;
      err_sticky <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    if (en) begin
      if (illegal) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
        good_nxt  = '0;
      end else begin
        // Every evaluated legal sample becomes the new reference.
        prev_nxt = q_in;
        unique case (state)
          IDLE, FAULT: begin
            state_nxt = ACQ;
            good_nxt  = '0;
          end
          ACQ: begin
            if (match) begin
              good_nxt = good_cnt + 1'b1;
              if (good_cnt == GW'(LOCK_CNT - 1)) state_nxt = LOCKED;
            end else begin
              good_nxt = '0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_nxt = (prev == TOP);
            end else begin
              err_nxt   = 1'b1;
              state_nxt = FAULT;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
    // A new error beats a simultaneous clear.
    sticky_nxt = err_nxt ? 1'b1 : (clr_err ? 1'b0 : err_sticky);
  end

  sat_counter #(.WIDTH(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_nxt),
    .clr   (1'b0),
    .count (wrap_count)
  );

`ifdef SEQMON_ERRCNT_EN
  sat_counter #(.WIDTH(8)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_nxt),
    .clr   (clr_err),
    .count (err_count)
  );
`endif
endmodule

// File: tb/tb_mod_counter_seq_monitor.sv
// Bench for mod_counter_seq_monitor: two instances (WRAP_W=8 and WRAP_W=2)
// share one stimulus stream; a queue of expected responses from a behavioural
// model is drained by an independent monitor one edge later.
module tb_mod_counter_seq_monitor;
  localparam int MOD = 7;
  localparam int LC  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, clr_err = 1'b0;
  logic [2:0] q_in = '0;
  logic       locked, seq_err, err_sticky, wrap_pulse;
  logic [7:0] wrap_count;
  logic       locked_s, seq_err_s, err_sticky_s, wrap_pulse_s;
  logic [1:0] wrap_count_s;
`ifdef SEQMON_ERRCNT_EN
  logic [7:0] err_count, err_count_s;
`endif

  always #5 clk = ~clk;

  mod_counter_seq_monitor #(.WIDTH(3), .MOD(MOD), .LOCK_CNT(LC), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked), .seq_err(seq_err), .err_sticky(err_sticky),
    .wrap_pulse(wrap_pulse),
`ifdef SEQMON_ERRCNT_EN
    .err_count(err_count),
`endif
    .wrap_count(wrap_count));

  mod_counter_seq_monitor #(.WIDTH(3), .MOD(MOD), .LOCK_CNT(LC), .WRAP_W(2)) dut_s (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked_s), .seq_err(seq_err_s), .err_sticky(err_sticky_s),
    .wrap_pulse(wrap_pulse_s),
`ifdef SEQMON_ERRCNT_EN
    .err_count(err_count_s),
`endif
    .wrap_count(wrap_count_s));

  typedef struct {
    bit lck, err, sticky, wrap;
    int wraps, errs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;

  // Behavioural model: "mode" names the phase, run counts good steps.
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_last = 0, m_run = 0, m_wraps = 0, m_errs = 0;
  bit    m_sticky = 0;

  function automatic exp_t model(bit r, bit e, int q, bit c);
    exp_t x;
    x.err = 0; x.wrap = 0;
    if (r) begin
      m_mode = M_IDLE; m_last = 0; m_run = 0; m_wraps = 0; m_errs = 0; m_sticky = 0;
    end else begin
      if (e) begin
        if (q >= MOD) begin
          x.err = 1; m_mode = M_IDLE; m_run = 0;
        end else begin
          bit ok = (q == (m_last + 1) % MOD);
          case (m_mode)
            M_IDLE, M_FAULT: begin m_mode = M_ACQ; m_run = 0; end
            M_ACQ: begin
              if (ok) begin m_run++; if (m_run == LC) m_mode = M_LOCK; end
              else m_run = 0;
            end
            M_LOCK: begin
              if (ok) begin
                if (m_last == MOD - 1) begin x.wrap = 1; m_wraps++; end
              end else begin
                x.err = 1; m_mode = M_FAULT;
              end
            end
          endcase
          m_last = q;
        end
      end
      if (x.err) m_sticky = 1; else if (c) m_sticky = 0;
      if (c) m_errs = x.err ? 1 : 0;
      else if (x.err && m_errs < 255) m_errs++;
    end
    x.lck = (m_mode == M_LOCK);
    x.sticky = m_sticky;
    x.wraps = m_wraps;
    x.errs = m_errs;
    return x;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string name, int act, int req);
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one response per edge, popped and compared 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      chk("locked",       int'(locked),       int'(e.lck));
      chk("seq_err",      int'(seq_err),      int'(e.err));
      chk("err_sticky",   int'(err_sticky),   int'(e.sticky));
      chk("wrap_pulse",   int'(wrap_pulse),   int'(e.wrap));
      chk("wrap_count",   int'(wrap_count),   sat(e.wraps, 255));
      chk("locked_s",     int'(locked_s),     int'(e.lck));
      chk("seq_err_s",    int'(seq_err_s),    int'(e.err));
      chk("wrap_pulse_s", int'(wrap_pulse_s), int'(e.wrap));
      chk("wrap_count_s", int'(wrap_count_s), sat(e.wraps, 3));
`ifdef SEQMON_ERRCNT_EN
      chk("err_count",    int'(err_count),    e.errs);
`endif
    end
  end

  task automatic step(bit r, bit e, int q, bit c);
    reset = r; en = e; q_in = 3'(q); clr_err = c;
    exp_q.push_back(model(r, e, q, c));
    @(posedge clk);
    #2;
  endtask

  task automatic run_seq(int first, int cnt);
    for (int i = 0; i < cnt; i++) step(0, 1, (first + i) % MOD, 0);
  endtask

  initial begin
    int last;
    int waitc;
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_wrap", int'(wrap_count), 0);

    // Lock-in on 0,1,2
    step(0, 1, 0, 0); chk("lock_after0", int'(locked), 0);
    step(0, 1, 1, 0); chk("lock_after1", int'(locked), 0);
    step(0, 1, 2, 0); chk("lock_after2", int'(locked), 1);
    chk("lock_noerr", int'(err_sticky), 0);

    // Wrap 3,4,5,6,0
    run_seq(3, 4);
    step(0, 1, 0, 0);
    chk("wrap_pulse_dir", int'(wrap_pulse), 1);
    chk("wrap_count_dir", int'(wrap_count), 1);
    step(0, 1, 1, 0);
    chk("wrap_pulse_drop", int'(wrap_pulse), 0);

    // Skip: locked at 3, drive 5
    step(0, 1, 2, 0); step(0, 1, 3, 0);
    step(0, 1, 5, 0);
    chk("skip_err", int'(seq_err), 1);
    chk("skip_unlock", int'(locked), 0);
    step(0, 1, 6, 0); chk("skip_errdrop", int'(seq_err), 0);
    step(0, 1, 0, 0); step(0, 1, 1, 0);
    chk("relock", int'(locked), 1);
    chk("sticky_held", int'(err_sticky), 1);
    step(0, 1, 2, 1);
    chk("sticky_clr", int'(err_sticky), 0);

    // Illegal code in LOCKED, IDLE, ACQ (last one with clr_err)
    step(0, 1, 7, 0); chk("ill_lock", int'(seq_err), 1);
    step(0, 1, 7, 1); chk("ill_idle", int'(seq_err), 1);
    step(0, 1, 0, 0);
    step(0, 1, 7, 1); chk("ill_acq", int'(seq_err), 1);
    chk("ill_clr_sticky", int'(err_sticky), 1);
    step(0, 1, 0, 1);

    // Saturation + hold + reset
    step(1, 0, 0, 0);
    for (int w = 0; w < 5; w++) run_seq(0, MOD);
    step(0, 1, 0, 0);
    chk("sat_big", int'(wrap_count), 5);
    chk("sat_small", int'(wrap_count_s), 3);
    for (int i = 0; i < 4; i++) step(0, 0, $urandom_range(0, 7), 0);
    chk("hold_wrap", int'(wrap_count), 5);
    chk("hold_lock", int'(locked), 1);
    step(1, 1, 3, 0);
    chk("rst2_wrap", int'(wrap_count), 0);
    chk("rst2_lock", int'(locked), 0);
    step(0, 1, 0, 0); step(0, 1, 1, 0);
    chk("relock_early", int'(locked), 0);
    step(0, 1, 2, 0);
    chk("relock3", int'(locked), 1);

    // Randomized traffic: mostly in-sequence with skips, illegal codes,
    // en gaps, clears and the occasional reset.
    last = 2;
    for (int i = 0; i < 3000; i++) begin
      int q;
      bit r, e, c;
      q = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : (last + 1) % MOD;
      e = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 299) == 0);
      if (e && q < MOD) last = q;
      step(r, e, q, c);
    end

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 10) begin
      @(posedge clk); #2; waitc++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
